// File: rtl/iob_normalize.sv
// -----------------------------------------------------------------------------
// iob_normalize / iob_ctls
//
// iob_ctls: combinational symbol counter. MODE=0 counts trailing SYMBOL bits,
//   MODE=1 counts leading SYMBOL bits. Result range 0..W.
//   data_i  [W-1:0]           input word
//   count_o [$clog2(W+1)-1:0] number of consecutive SYMBOL bits
//
// iob_normalize: two-stage normalizer for a mantissa/exponent pair.
//   S1 registers the word and its leading-zero count. S2 shifts the mantissa
//   left by min(lz, exp) and reduces the exponent by the same amount.
//   Ready/valid handshake on both sides, with a global clock enable.
//   clk_i, arst_n_i (async, active-low), cke_i
//   valid_i/ready_o/data_i/exp_i                   : input stream
//   valid_o/ready_i/data_o/exp_o/shift_o/zero_o/
//   underflow_o                                    : output stream
// -----------------------------------------------------------------------------

module iob_ctls #(
   parameter int W      = 32,
   parameter int MODE   = 0,
   parameter int SYMBOL = 0
) (
   input  logic [W-1:0]             data_i,
   output logic [$clog2(W+1)-1:0]   count_o
);

   localparam int   CNT_W = $clog2(W+1);
   localparam logic SYM   = 1'(SYMBOL);

   // The last non-symbol bit visited wins, so the scan direction decides
   // whether leading or trailing symbols are counted.
   always_comb begin
      count_o = CNT_W'(W);
      if (MODE == 0) begin
         for (int unsigned i = W; i > 0; i--) begin
            if (data_i[i-1] != SYM) begin
               count_o = CNT_W'(i - 1);
            end
         end
      end else begin
         for (int unsigned i = 0; i < W; i++) begin
            if (data_i[i] != SYM) begin
               count_o = CNT_W'(W - 1 - i);
            end
         end
      end
   end

endmodule

module iob_normalize #(
   parameter int DATA_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic                      cke_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [DATA_W-1:0]         data_i,
   input  logic [EXP_W-1:0]          exp_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_W-1:0]         data_o,
   output logic [EXP_W-1:0]          exp_o,
   output logic [$clog2(DATA_W):0]   shift_o,
   output logic                      zero_o,
   output logic                      underflow_o
);

   localparam int SH_W = $clog2(DATA_W) + 1;
   localparam int LZ_W = $clog2(DATA_W + 1);
   localparam int CW   = (SH_W > EXP_W) ? SH_W : EXP_W;

   // ---------------- stage registers ----------------
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
   logic [SH_W-1:0]   s1_lz_q,    s1_lz_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
   logic [SH_W-1:0]   s2_shift_q, s2_shift_d;
   logic              s2_zero_q,  s2_zero_d;
   logic              s2_uf_q,    s2_uf_d;

   // ---------------- combinational helpers ----------------
   logic [LZ_W-1:0]   lz_w;
   logic              s2_free;
   logic              s1_load;
   logic              s2_load;
   logic [CW-1:0]     lz_c, exp_c, sh_c, exp_red_c;
   logic              zero_c, uf_c;

   iob_ctls #(
      .W      (DATA_W),
      .MODE   (1),
      .SYMBOL (0)
   ) u_ctls (
      .data_i  (data_i),
      .count_o (lz_w)
   );

   // S2 can take a word when empty or when its word leaves this cycle.
   // S1 can take a word when empty or when its word moves into S2.
   assign s2_free = !s2_valid_q || ready_i;
   assign ready_o = !s1_valid_q || s2_free;
   assign s1_load = cke_i && ready_o;
   assign s2_load = cke_i && s2_free;

   // Shift amount = min(lz, exp); compared at a common width so neither
   // operand is truncated.
   always_comb begin
      lz_c      = CW'(s1_lz_q);
      exp_c     = CW'(s1_exp_q);
      zero_c    = (s1_data_q == '0);
      uf_c      = (lz_c > exp_c) && !zero_c;
      sh_c      = zero_c ? '0 : (uf_c ? exp_c : lz_c);
      exp_red_c = exp_c - sh_c;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_exp_d   = s1_exp_q;
      s1_lz_d    = s1_lz_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_exp_d   = s2_exp_q;
      s2_shift_d = s2_shift_q;
      s2_zero_d  = s2_zero_q;
      s2_uf_d    = s2_uf_q;

      // A load with valid_i low leaves a bubble; data registers keep old
      // contents since they are qualified by the valid flag.
      if (s1_load) begin
         s1_valid_d = valid_i;
         if (valid_i) begin
            s1_data_d = data_i;
            s1_exp_d  = exp_i;
            s1_lz_d   = SH_W'(lz_w);
         end
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d  = zero_c ? '0 : (s1_data_q << sh_c);
            s2_exp_d   = (zero_c || uf_c) ? '0 : exp_red_c[EXP_W-1:0];
            s2_shift_d = sh_c[SH_W-1:0];
            s2_zero_d  = zero_c;
            s2_uf_d    = uf_c;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_exp_q   <= '0;
         s1_lz_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_exp_q   <= '0;
         s2_shift_q <= '0;
         s2_zero_q  <= 1'b0;
         s2_uf_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_exp_q   <= s1_exp_d;
         s1_lz_q    <= s1_lz_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_exp_q   <= s2_exp_d;
         s2_shift_q <= s2_shift_d;
         s2_zero_q  <= s2_zero_d;
         s2_uf_q    <= s2_uf_d;
      end
   end

   assign valid_o     = s2_valid_q;
   assign data_o      = s2_data_q;
   assign exp_o       = s2_exp_q;
   assign shift_o     = s2_shift_q;
   assign zero_o      = s2_zero_q;
   assign underflow_o = s2_uf_q;

endmodule
